jtag_dr_cell_chain: RTL and testbench

Parametrised JTAG data-register cell chain: capture, shift and update stages with bit-length checking and an optional 1-bit bypass path. Everything runs in the system-clock domain. It sits between the TAP controller, which supplies the `capture_dr`/`shift_dr`/`update_dr` strobes, and the core-side parallel register it drives. It replaces hand-instantiated chains of single-bit resettable D flip-flops.

---
 rtl/jtag_dr_cell_chain_if.sv | 28 ++
 rtl/jtag_dr_cell_chain.sv | 72 +++++++
 tb/tb_jtag_dr_cell_chain.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/jtag_dr_cell_chain_if.sv
// TAP-side bundle for a JTAG data-register cell chain: strobes, serial
// in/out and the parallel core-side capture/update buses.
interface jtag_dr_cell_chain_if #(
  parameter int WIDTH = 8
);
  logic             capture_dr;
  logic             shift_dr;
  logic             update_dr;
  logic             bypass;
  logic             tdi;
  logic [WIDTH-1:0] par_in;
  logic             tdo;
  logic [WIDTH-1:0] par_out;
  logic             upd_pulse;
  logic             len_err;

  // TAP controller / core side
  modport master (
    output capture_dr, shift_dr, update_dr, bypass, tdi, par_in,
    input  tdo, par_out, upd_pulse, len_err
  );

  // cell chain side
  modport slave (
    input  capture_dr, shift_dr, update_dr, bypass, tdi, par_in,
    output tdo, par_out, upd_pulse, len_err
  );
endinterface

// File: rtl/jtag_dr_cell_chain.sv
// JTAG data-register cell chain: capture / shift / update stages with an
// optional shift-length check and a 1-bit bypass path, all on clk.
module jtag_dr_cell_chain #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               STRICT_LEN  = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  jtag_dr_cell_chain_if.slave   bus
);
  // counter must reach WIDTH+1 so overshift is distinguishable from exact
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CAPT  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] par_out;
  logic             byp;
  logic [CW-1:0]    cnt;
  logic [1:0]       state;
  logic             upd_pulse;
  logic             len_err;
  logic             len_ok;

  assign len_ok = !STRICT_LEN || (cnt == CW'(WIDTH));

  // strobe decode with capture > shift > update priority; bypass diverts
  // capture/shift to the 1-bit register and swallows update entirely
  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= RESET_VALUE;
      par_out   <= RESET_VALUE;
      byp       <= 1'b0;
      cnt       <= '0;
      state     <= IDLE;
      upd_pulse <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      upd_pulse <= 1'b0;
      if (bus.bypass) begin
        if (bus.capture_dr)    byp <= 1'b0;
        else if (bus.shift_dr) byp <= bus.tdi;
      end else if (bus.capture_dr) begin
        sr      <= bus.par_in;
        cnt     <= '0;
        len_err <= 1'b0;
        state   <= CAPT;
      end else if (bus.shift_dr) begin
        sr    <= {bus.tdi, sr[WIDTH-1:1]};
        // from CAPT cnt is 0, so the saturating increment yields 1
        if (cnt != CW'(WIDTH + 1)) cnt <= cnt + 1'b1;
        state <= SHIFT;
      end else if (bus.update_dr && state != IDLE) begin
        if (len_ok) begin
          par_out   <= sr;
          upd_pulse <= 1'b1;
        end else begin
          len_err   <= 1'b1;
        end
        state <= IDLE;
      end
    end
  end

  assign bus.tdo       = bus.bypass ? byp : sr[0];
  assign bus.par_out   = par_out;
  assign bus.upd_pulse = upd_pulse;
  assign bus.len_err   = len_err;
endmodule

// File: tb/tb_jtag_dr_cell_chain.sv
// Bench for jtag_dr_cell_chain: a strict and a lenient instance share one
// stimulus stream; a queue-based model is compared every cycle and directed
// literal expectations pin the model.
module tb_jtag_dr_cell_chain;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, cap = 1'b0, sh = 1'b0, upd = 1'b0, byp = 1'b0, tdi = 1'b0;
  logic [7:0] pin = 8'h00;
  int         errs = 0, checks = 0;

  jtag_dr_cell_chain_if #(.WIDTH(8)) b0 ();
  jtag_dr_cell_chain_if #(.WIDTH(8)) b1 ();

  assign b0.capture_dr = cap; assign b1.capture_dr = cap;
  assign b0.shift_dr   = sh;  assign b1.shift_dr   = sh;
  assign b0.update_dr  = upd; assign b1.update_dr  = upd;
  assign b0.bypass     = byp; assign b1.bypass     = byp;
  assign b0.tdi        = tdi; assign b1.tdi        = tdi;
  assign b0.par_in     = pin; assign b1.par_in     = pin;

  jtag_dr_cell_chain #(.WIDTH(8), .RESET_VALUE(8'hA5), .STRICT_LEN(1'b1))
    dut_strict (.clk(clk), .reset(rst), .bus(b0));
  jtag_dr_cell_chain #(.WIDTH(8), .RESET_VALUE(8'hA5), .STRICT_LEN(1'b0))
    dut_loose  (.clk(clk), .reset(rst), .bus(b1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: register contents as a bit queue, LSB at head
  logic       mq [2][$];
  int         mshifted [2];   // bits shifted since last capture/reset, unbounded
  bit         marmed [2];     // a capture or shift happened since last update/reset
  logic [7:0] mpar [2];
  logic       mpul [2], merr [2], mbyp [2];
  logic [7:0] rv = 8'hA5;

  function automatic logic [7:0] mpack(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = mq[k][i];
    return v;
  endfunction

  function automatic logic mtdo(input int k);
    return byp ? mbyp[k] : mq[k][0];
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mq[k].push_back(rv[i]);
      mshifted[k] = 0; marmed[k] = 0; mpar[k] = rv;
      mpul[k] = 0; merr[k] = 0; mbyp[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mpul[k] = 1'b0;
      if (rst) begin
        mq[k].delete();
        for (int i = 0; i < 8; i++) mq[k].push_back(rv[i]);
        mshifted[k] = 0; marmed[k] = 0; mpar[k] = rv; merr[k] = 0; mbyp[k] = 0;
      end else if (byp) begin
        if (cap)     mbyp[k] = 1'b0;
        else if (sh) mbyp[k] = tdi;
      end else if (cap) begin
        mq[k].delete();
        for (int i = 0; i < 8; i++) mq[k].push_back(pin[i]);
        mshifted[k] = 0; merr[k] = 0; marmed[k] = 1;
      end else if (sh) begin
        void'(mq[k].pop_front());
        mq[k].push_back(tdi);
        mshifted[k]++; marmed[k] = 1;
      end else if (upd && marmed[k]) begin
        marmed[k] = 0;
        if (k == 1 || mshifted[k] == 8) begin
          mpar[k] = mpack(k); mpul[k] = 1'b1;
        end else begin
          merr[k] = 1'b1;
        end
      end
    end
  end

  // every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("s_tdo",   32'(b0.tdo),       32'(mtdo(0)));
    chk("s_par",   32'(b0.par_out),   32'(mpar[0]));
    chk("s_pulse", 32'(b0.upd_pulse), 32'(mpul[0]));
    chk("s_err",   32'(b0.len_err),   32'(merr[0]));
    chk("l_tdo",   32'(b1.tdo),       32'(mtdo(1)));
    chk("l_par",   32'(b1.par_out),   32'(mpar[1]));
    chk("l_pulse", 32'(b1.upd_pulse), 32'(mpul[1]));
    chk("l_err",   32'(b1.len_err),   32'(merr[1]));
  end

  // ---------------- stimulus
  task automatic step(input logic c, input logic s, input logic u, input logic t,
                      input logic [7:0] p = 8'h00);
    cap = c; sh = s; upd = u; tdi = t; pin = p;
    @(posedge clk); #2;
    cap = 0; sh = 0; upd = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] tin, exp3c;
    tin = 8'h96; exp3c = 8'h3C;

    // 1: reset with random strobes
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    rst = 1'b0;
    chk("rst_par", 32'(b0.par_out), 32'h A5);
    chk("rst_tdo", 32'(b0.tdo), 32'h1);
    chk("rst_pulse", 32'(b0.upd_pulse), 32'h0);
    chk("rst_err", 32'(b0.len_err), 32'h0);

    // 2: full capture/shift/update
    step(1, 0, 0, 0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      chk("full_tdo", 32'(b0.tdo), 32'(exp3c[i]));
      step(0, 1, 0, tin[i]);
    end
    step(0, 0, 1, 0);
    chk("full_par", 32'(b0.par_out), 32'h96);
    chk("full_pulse1", 32'(b0.upd_pulse), 32'h1);
    step(0, 0, 1, 0);  // back-to-back update: ignored in IDLE
    chk("full_pulse0", 32'(b0.upd_pulse), 32'h0);
    chk("full_par_hold", 32'(b0.par_out), 32'h96);

    // 3: length errors
    do_reset();
    step(1, 0, 0, 0, 8'h3C);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("len7_par", 32'(b0.par_out), 32'hA5);
    chk("len7_err", 32'(b0.len_err), 32'h1);
    chk("len7_loose_par", 32'(b1.par_out), 32'h00);
    chk("len7_loose_err", 32'(b1.len_err), 32'h0);
    step(1, 0, 0, 0, 8'h3C);
    chk("cap_clr_err", 32'(b0.len_err), 32'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 1);
    step(0, 0, 1, 0);
    chk("len9_err", 32'(b0.len_err), 32'h1);
    chk("len9_par", 32'(b0.par_out), 32'hA5);
    chk("len9_loose_par", 32'(b1.par_out), 32'hFF);

    // 4: simultaneous strobes
    step(1, 1, 0, 1, 8'hF0);
    chk("capsh_tdo", 32'(b0.tdo), 32'h0);
    step(0, 1, 1, 1);
    chk("shupd_pulse", 32'(b0.upd_pulse), 32'h0);
    chk("shupd_par", 32'(b0.par_out), 32'hA5);

    // 5: bypass
    byp = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0, 8'hFF);
    chk("byp_cap", 32'(b0.tdo), 32'h0);
    step(0, 1, 0, 1);
    chk("byp_t1", 32'(b0.tdo), 32'h1);
    step(0, 1, 0, 0);
    chk("byp_t0", 32'(b0.tdo), 32'h0);
    step(0, 1, 0, 1);
    chk("byp_t1b", 32'(b0.tdo), 32'h1);
    step(0, 0, 1, 0);
    chk("byp_pulse", 32'(b0.upd_pulse), 32'h0);
    chk("byp_par", 32'(b0.par_out), 32'hA5);
    step(0, 0, 0, 0);
    byp = 1'b0;
    step(0, 0, 0, 0);

    // 6: reset mid-shift
    step(1, 0, 0, 0, 8'h3C);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1);
    do_reset();
    step(0, 0, 1, 0);
    chk("mid_par", 32'(b0.par_out), 32'hA5);
    chk("mid_tdo", 32'(b0.tdo), 32'h1);
    chk("mid_pulse", 32'(b0.upd_pulse), 32'h0);
    chk("mid_err", 32'(b0.len_err), 32'h0);

    step(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
